// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the bit-serial CRC32 byte update.
// Latency: n/a (package).
// Backpressure: n/a (package).
package eth_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] ETH_POLY    = 32'h04C1_1DB7;
    localparam int          FCS_BYTES   = 4;

    // MSB-first state; byte bits enter LSB first, matching wire order.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ ETH_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32.sv
// CRC32 single-byte update of the running Ethernet CRC state.
// Latency: combinational.
// Backpressure: none; caller decides when to commit the next state.
module crc32
    import eth_pkg::*;
(
    input  logic [31:0] i_crc_state,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc_state
);

    assign o_crc_state = crc32_byte(i_crc_state, i_data);

endmodule

// File: rtl/eth_fcs_checker.sv
// RX FCS checker: running CRC over all bytes, strips 4 FCS bytes, flags good/bad frames.
// Latency: payload byte N leaves 1 cycle after input byte N+4 is accepted.
// Backpressure: single output register; input ready only when it is empty or draining.
module eth_fcs_checker
    import eth_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] RESIDUE    = CRC_RESIDUE
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] s_rx_tdata,
    input  logic                  s_rx_tvalid,
    input  logic                  s_rx_tlast,
    output logic                  s_rx_tready,
    output logic [DATA_WIDTH-1:0] m_rx_tdata,
    output logic                  m_rx_tvalid,
    output logic                  m_rx_tlast,
    output logic                  m_rx_tuser,
    input  logic                  m_rx_tready,
    output logic                  o_fcs_good,
    output logic                  o_fcs_bad,
    output logic                  o_runt,
    output logic [15:0]           o_bad_cnt
);

    logic                  accept;
    logic                  eof;
    logic                  full;
    logic                  crc_ok;
    logic [CRC_WIDTH-1:0]  crc_q;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic [2:0]            cnt;
    logic [DATA_WIDTH-1:0] shreg [FCS_BYTES];

    assign s_rx_tready = !m_rx_tvalid || m_rx_tready;
    assign accept      = s_rx_tvalid && s_rx_tready;
    assign eof         = accept && s_rx_tlast;
    assign full        = (cnt == 3'(FCS_BYTES));
    assign crc_ok      = (crc_next == RESIDUE);

    crc32 u_crc32 (
        .i_crc_state (crc_q),
        .i_data      (s_rx_tdata),
        .o_crc_state (crc_next)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_q <= CRC_INIT;
        end else if (accept) begin
            crc_q <= s_rx_tlast ? CRC_INIT : crc_next;
        end
    end

    // The last four bytes seen are held back: at end of frame they are the FCS.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
            for (int i = 0; i < FCS_BYTES; i++) begin
                shreg[i] <= '0;
            end
        end else begin
            if (accept) begin
                shreg[0] <= s_rx_tdata;
                for (int i = 1; i < FCS_BYTES; i++) begin
                    shreg[i] <= shreg[i-1];
                end
            end
            if (eof) begin
                cnt <= '0;
            end else if (accept && !full) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_rx_tdata  <= '0;
            m_rx_tvalid <= 1'b0;
            m_rx_tlast  <= 1'b0;
            m_rx_tuser  <= 1'b0;
        end else if (accept && full) begin
            m_rx_tdata  <= shreg[FCS_BYTES-1];
            m_rx_tvalid <= 1'b1;
            m_rx_tlast  <= s_rx_tlast;
            m_rx_tuser  <= s_rx_tlast && !crc_ok;
        end else if (m_rx_tready) begin
            m_rx_tvalid <= 1'b0;
        end
    end

    // A runt never reaches the CRC comparison; it is reported bad outright.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fcs_good <= 1'b0;
            o_fcs_bad  <= 1'b0;
            o_runt     <= 1'b0;
            o_bad_cnt  <= '0;
        end else begin
            o_fcs_good <= eof && full && crc_ok;
            o_fcs_bad  <= eof && !(full && crc_ok);
            o_runt     <= eof && !full;
            if (o_fcs_bad && (o_bad_cnt != 16'hFFFF)) begin
                o_bad_cnt <= o_bad_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Directed bench for eth_fcs_checker: good, bad, runt, backpressure, back-to-back and reset.
module tb_eth_fcs_checker;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [7:0] s_rx_tdata = 8'h00;
    logic       s_rx_tvalid = 1'b0;
    logic       s_rx_tlast = 1'b0;
    logic       s_rx_tready;
    logic [7:0] m_rx_tdata;
    logic       m_rx_tvalid;
    logic       m_rx_tlast;
    logic       m_rx_tuser;
    logic       m_rx_tready = 1'b1;
    logic       o_fcs_good;
    logic       o_fcs_bad;
    logic       o_runt;
    logic [15:0] o_bad_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int good_p = 0;
    int bad_p = 0;
    int runt_p = 0;
    int bp_cyc = 0;
    int good_before = 0;
    int bad_before = 0;
    logic       bp_en = 1'b0;
    logic       stalled_prev = 1'b0;
    logic [9:0] held = '0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    eth_fcs_checker dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .s_rx_tdata  (s_rx_tdata),
        .s_rx_tvalid (s_rx_tvalid),
        .s_rx_tlast  (s_rx_tlast),
        .s_rx_tready (s_rx_tready),
        .m_rx_tdata  (m_rx_tdata),
        .m_rx_tvalid (m_rx_tvalid),
        .m_rx_tlast  (m_rx_tlast),
        .m_rx_tuser  (m_rx_tuser),
        .m_rx_tready (m_rx_tready),
        .o_fcs_good  (o_fcs_good),
        .o_fcs_bad   (o_fcs_bad),
        .o_runt      (o_runt),
        .o_bad_cnt   (o_bad_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from register updates.
    initial forever begin
        @(negedge i_clk);
        if (!i_reset_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                check("hold", 32'({m_rx_tlast, m_rx_tuser, m_rx_tdata}), 32'(held));
            if (m_rx_tvalid && m_rx_tlast && !stalled_prev)
                check("eof_status", 32'({o_fcs_good, o_fcs_bad}), 32'({!m_rx_tuser, m_rx_tuser}));
            if (m_rx_tvalid && !m_rx_tready)
                check("stall_rdy", 32'(s_rx_tready), 0);
            if (m_rx_tvalid && m_rx_tready)
                got_q.push_back({m_rx_tlast, m_rx_tuser, m_rx_tdata});
            if (o_runt)
                check("runt_bad", 32'(o_fcs_bad), 1);
            if (o_fcs_good) good_p++;
            if (o_fcs_bad)  bad_p++;
            if (o_runt)     runt_p++;
            stalled_prev = m_rx_tvalid && !m_rx_tready;
            held = {m_rx_tlast, m_rx_tuser, m_rx_tdata};
        end
    end

    // Downstream ready: always high, or 1-on/2-off when backpressure is enabled.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (bp_en) begin
            bp_cyc++;
            m_rx_tready = (bp_cyc % 3 == 0);
        end else begin
            m_rx_tready = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int   waited;
        logic rdy;
        waited = 0;
        s_rx_tvalid = 1'b1;
        s_rx_tdata  = d;
        s_rx_tlast  = l;
        do begin
            @(negedge i_clk);
            rdy = s_rx_tready;
            @(posedge i_clk);
            #1;
            waited++;
        end while (!rdy && waited < 50);
        if (!rdy) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i], i == f.size() - 1);
    endtask

    task automatic idle(input int n);
        s_rx_tvalid = 1'b0;
        s_rx_tlast  = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic append_exp(input logic [7:0] p[$], input logic user);
        foreach (p[i]) begin
            logic last;
            last = (i == p.size() - 1);
            exp_q.push_back({last, last & user, p[i]});
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] payload[$];
        logic [7:0] good_f[$];
        logic [7:0] bad_f[$];
        logic [7:0] runt_f[$];
        payload = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        good_f  = {payload, 8'h26, 8'h39, 8'hF4, 8'hCB};
        bad_f   = {payload, 8'h26, 8'h39, 8'hF4, 8'hCA};
        runt_f  = '{8'hAA, 8'hBB, 8'hCC};

        #12;
        check("rst_tvalid", 32'(m_rx_tvalid), 0);
        check("rst_tlast",  32'(m_rx_tlast), 0);
        check("rst_tuser",  32'(m_rx_tuser), 0);
        check("rst_tdata",  32'(m_rx_tdata), 0);
        check("rst_good",   32'(o_fcs_good), 0);
        check("rst_bad",    32'(o_fcs_bad), 0);
        check("rst_runt",   32'(o_runt), 0);
        check("rst_badcnt", 32'(o_bad_cnt), 0);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("rst_tready", 32'(s_rx_tready), 1);

        // Good frame "123456789" with FCS CBF43926
        append_exp(payload, 1'b0);
        send_frame(good_f);
        idle(10);
        check_out("good");
        check("good_pulses", good_p, 1);
        check("good_nobad",  bad_p, 0);
        check("good_badcnt", 32'(o_bad_cnt), 0);

        // Corrupted last FCS byte
        append_exp(payload, 1'b1);
        send_frame(bad_f);
        idle(10);
        check_out("bad");
        check("bad_pulses",  bad_p, 1);
        check("bad_nogood",  good_p, 1);
        check("bad_badcnt",  32'(o_bad_cnt), 1);

        // 3-byte runt
        send_frame(runt_f);
        idle(10);
        check_out("runt");
        check("runt_pulses", runt_p, 1);
        check("runt_bad_p",  bad_p, 2);
        check("runt_badcnt", 32'(o_bad_cnt), 2);

        // Backpressure 1-on/2-off
        bp_en = 1'b1;
        append_exp(payload, 1'b0);
        send_frame(good_f);
        idle(20);
        bp_en = 1'b0;
        idle(2);
        check_out("bp");
        check("bp_good_p", good_p, 2);

        // Two frames with no gap
        append_exp(payload, 1'b0);
        append_exp(payload, 1'b0);
        send_frame(good_f);
        send_frame(good_f);
        idle(10);
        check_out("b2b");
        check("b2b_good_p", good_p, 4);
        check("b2b_bad_p",  bad_p, 2);

        // Reset after 5 bytes of a frame
        good_before = good_p;
        bad_before  = bad_p;
        for (int i = 0; i < 5; i++) send_byte(good_f[i], 1'b0);
        i_reset_n   = 1'b0;
        s_rx_tvalid = 1'b0;
        #2;
        check("mid_rst_tvalid", 32'(m_rx_tvalid), 0);
        check("mid_rst_tlast",  32'(m_rx_tlast), 0);
        check("mid_rst_good",   32'(o_fcs_good), 0);
        check("mid_rst_bad",    32'(o_fcs_bad), 0);
        check("mid_rst_badcnt", 32'(o_bad_cnt), 0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        got_q.delete();
        #1;
        check("mid_rst_tready", 32'(s_rx_tready), 1);
        append_exp(payload, 1'b0);
        send_frame(good_f);
        idle(10);
        check_out("post_rst");
        check("post_rst_good_p", good_p, good_before + 1);
        check("post_rst_bad_p",  bad_p, bad_before);
        check("post_rst_badcnt", 32'(o_bad_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
